// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - command-to-APB requester bridge (IDLE/SETUP/ACCESS)
// Optional ACCESS abort timer is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strb,
  input  logic [2:0]  req_prot,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_slverr,
  output logic        rsp_timeout,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  output logic [2:0]  PPROT,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  state_e      state_q;
  logic        req_ready_q;
  logic        psel_q;
  logic        penable_q;
  logic        pwrite_q;
  logic [31:0] paddr_q;
  logic [31:0] pwdata_q;
  logic [3:0]  pstrb_q;
  logic [2:0]  pprot_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_slverr_q;

  // The wait counter is 16 bits wide, so TIMEOUT_CYCLES must stay within 1..65535.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
  end

`ifdef APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt_q;
  logic        rsp_timeout_q;
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      psel_q       <= 1'b0;
      penable_q    <= 1'b0;
      pwrite_q     <= 1'b0;
      paddr_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      pprot_q      <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
      to_cnt_q      <= '0;
      rsp_timeout_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q     <= SETUP;
            req_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= req_write;
            paddr_q     <= req_addr;
            pwdata_q    <= req_write ? req_wdata : 32'h0;
            pstrb_q     <= req_write ? req_strb : 4'h0;
            pprot_q     <= req_prot;
`ifdef APB_MASTER_TIMEOUT_EN
            to_cnt_q    <= '0;
`endif
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          // PREADY is checked first so a completer answering on the last allowed cycle still wins.
          if (PREADY) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_rdata_q  <= pwrite_q ? 32'h0 : PRDATA;
            rsp_slverr_q <= PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
          end
`ifdef APB_MASTER_TIMEOUT_EN
          else if (to_cnt_q == TO_LAST) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b1;
            rsp_rdata_q   <= 32'h0;
            rsp_slverr_q  <= 1'b1;
            rsp_timeout_q <= 1'b1;
          end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign PSEL       = psel_q;
  assign PENABLE    = penable_q;
  assign PWRITE     = pwrite_q;
  assign PADDR      = paddr_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign PPROT      = pprot_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_slverr = rsp_slverr_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - randomized self-checking bench for apb_master_bridge
// Timeout expectations follow APB_MASTER_TIMEOUT_EN, matching the DUT build.
module tb_apb_master_bridge;

  localparam int unsigned TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] K = 32'hA5A5_0000;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic garble();
    PREADY  = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA  = $urandom;
  endtask

  // One transfer; the completer raises PREADY after wait_n low ACCESS cycles.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [2:0] prot, input int wait_n,
                          input logic [31:0] rdata, input bit err);
    bit          tmo;
    int          nacc;
    logic [71:0] bus;
    logic [33:0] rsp;
    tmo  = TO_EN && (wait_n >= int'(TO));
    nacc = tmo ? int'(TO) : wait_n + 1;
    bus  = {addr, wr ? wdata : 32'h0, wr ? strb : 4'h0, prot, wr};
    rsp  = tmo ? {32'h0, 1'b1, 1'b1} : {wr ? 32'h0 : rdata, err, 1'b0};

    req_valid = 1'b1; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_strb = strb; req_prot = prot;
    garble();
    check("idle_ready", {PSEL, PENABLE, req_ready}, 3'b001);
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_strb = 4'($urandom); req_prot = 3'($urandom);
    garble();
    check("setup_ctl", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b1000);
    check("setup_bus", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, bus);
    tick();
    for (int k = 0; k < nacc; k++) begin
      check("access_ctl", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b1100);
      check("access_bus", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, bus);
      if (!tmo && k == wait_n) begin
        PREADY = 1'b1; PSLVERR = err; PRDATA = rdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
      end
      tick();
    end
    garble();
    check("rsp_ctl", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b0011);
    check("rsp_data", {rsp_rdata, rsp_slverr, rsp_timeout}, rsp);
    check("idle_hold", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, bus);
    tick();
    check("rsp_pulse", {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    logic [31:0] cmds [3];
    int          idx, nrsp;
    bit          acc;

    PRESETn = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
    #1 PRESETn = 1'b0;
    #1;
    check("reset_ctl", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b0010);
    check("reset_bus", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, 72'h0);
    check("reset_rsp", {rsp_rdata, rsp_slverr, rsp_timeout}, 34'h0);
    tick();
    PRESETn = 1'b1;
    tick();

    run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'h0, 0, 32'h0, 1'b0);
    run_xfer(1'b0, 32'h20, 32'hCAFEF00D, 4'hA, 3'h2, 3, 32'h12345678, 1'b0);
    run_xfer(1'b1, 32'h30, 32'h0BADCAFE, 4'h3, 3'h5, 1, 32'h0, 1'b1);
    run_xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'h7, 100, 32'h55AA55AA, 1'b0);
    for (int i = 0; i < 40; i++)
      run_xfer(1'($urandom), $urandom, $urandom, 4'($urandom), 3'($urandom),
               int'($urandom_range(0, 6)), $urandom, 1'($urandom));

    cmds[0] = 32'h100; cmds[1] = 32'h204; cmds[2] = 32'h308;
    idx = 0; nrsp = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = (idx < 3); req_write = 1'b0; req_addr = cmds[idx % 3];
      PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = PADDR ^ K;
      check("b2b_psel_ready", {PSEL, req_ready}, {(c % 3) != 0, (c % 3) == 0});
      check("b2b_rsp_valid", rsp_valid, (c > 0) && (c % 3 == 0));
      if (rsp_valid && nrsp < 3) begin
        check("b2b_rdata", rsp_rdata, cmds[nrsp] ^ K);
        nrsp++;
      end
      acc = req_valid && req_ready;
      tick();
      if (acc) idx++;
    end
    check("b2b_count", nrsp, 3);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h77; req_wdata = 32'h1234;
    req_strb = 4'h5; req_prot = 3'h1; PREADY = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    check("rst_pre", {PSEL, PENABLE}, 2'b11);
    #3 PRESETn = 1'b0;
    #1;
    check("rst_async_ctl", {PSEL, PENABLE, req_ready, rsp_valid}, 4'b0010);
    check("rst_async_bus", {PADDR, PWDATA, PSTRB, PPROT, PWRITE}, 72'h0);
    check("rst_async_rsp", {rsp_rdata, rsp_slverr, rsp_timeout}, 34'h0);
    tick();
    tick();
    #3 PRESETn = 1'b1;
    PREADY = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("rst_no_rsp", {rsp_valid, req_ready, PSEL}, 3'b010);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of ACCESS cycles with PREADY low before abort (range 1..65535).
REQ-002 SHALL have port PCLK, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port PRESETn, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1, command valid.
REQ-005 SHALL have port req_ready, output, 1, bridge can accept a command.
REQ-006 SHALL have req_write (1), req_addr (32), req_wdata (32), req_strb (4) and req_prot (3), all inputs, giving command direction, address, write data, byte strobes and protection.
REQ-007 SHALL have rsp_valid (1), rsp_rdata (32), rsp_slverr (1) and rsp_timeout (1), all outputs, giving the response pulse, read data, error flag and timeout flag.
REQ-008 SHALL have outputs PSEL, PENABLE, PWRITE (1 each), PADDR (32), PWDATA (32), PSTRB (4) and PPROT (3), the APB requester outputs.
REQ-009 SHALL have inputs PRDATA (32), PREADY (1) and PSLVERR (1), the APB completer outputs.

Function
REQ-010 SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-011 SHALL assert req_ready=1 only in IDLE.
REQ-012 SHALL accept a command when req_valid and req_ready are both high, register all req_* fields and move IDLE->SETUP.
REQ-013 SHALL, in SETUP, drive PSEL=1 and PENABLE=0 with PADDR, PWRITE and PPROT from the captured fields, then move unconditionally SETUP->ACCESS.
REQ-014 SHALL, in ACCESS, drive PSEL=1 and PENABLE=1 and hold all APB address, control and data outputs stable until completion.
REQ-015 SHALL, on a write, drive PWDATA and PSTRB from the captured fields, and on a read drive PSTRB=4'h0 and PWDATA=32'h0.
REQ-016 SHALL complete in ACCESS when PREADY=1: move to IDLE, and in the next cycle pulse rsp_valid for exactly one cycle.
REQ-017 SHALL set rsp_slverr equal to PSLVERR sampled at completion.
REQ-018 SHALL set rsp_rdata to PRDATA sampled at completion for reads and 32'h0 for writes.
REQ-019 SHALL ignore PREADY, PSLVERR and PRDATA outside ACCESS.
REQ-020 SHALL provide a minimum transaction timing of: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid and req_ready both at N+3 when PREADY=1 at N+2.
REQ-021 SHALL extend ACCESS by one cycle per cycle of PREADY=0, with no upper bound unless the timeout feature is compiled in.
REQ-022 SHALL provide no response backpressure: rsp_valid is a pulse that the consumer must take.
REQ-023 SHALL drive PSEL=0 and PENABLE=0 in IDLE, with the other APB outputs holding their last values.
REQ-024 SHALL keep rsp_rdata, rsp_slverr and rsp_timeout valid only while rsp_valid=1; they may hold at other times.

Reset
REQ-025 SHALL, while PRESETn=0, immediately force state=IDLE and PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout and the timeout counter to 0, with req_ready=1.
REQ-026 SHALL, on a reset in SETUP or ACCESS, drop the transfer with no rsp_valid issued for it.

Configuration
REQ-027 SHALL, with macro APB_MASTER_TIMEOUT_EN defined, count consecutive ACCESS cycles with PREADY=0, and when the count reaches TIMEOUT_CYCLES, abort to IDLE and pulse rsp_valid next cycle with rsp_slverr=1, rsp_timeout=1 and rsp_rdata=0.
REQ-028 SHALL clear the timeout counter on each entry to SETUP.
REQ-029 SHALL let PREADY=1 in the same cycle the count reaches TIMEOUT_CYCLES win, giving a normal completion with rsp_timeout=0.
REQ-030 SHALL, with APB_MASTER_TIMEOUT_EN undefined, contain no counter logic, tie rsp_timeout to 0 and wait for PREADY indefinitely.

Verification
REQ-031 SHALL cover a write with addr 0x10, data 0xDEADBEEF, strb 0xF and PREADY=1 immediately -> SETUP at N+1, ACCESS at N+2, rsp_valid at N+3, rsp_slverr=0, rsp_rdata=0.
REQ-032 SHALL cover a read of 0x20 with PREADY low for 3 ACCESS cycles and PRDATA=0x12345678 -> PSTRB=0, APB outputs stable for 4 ACCESS cycles, rsp_rdata=0x12345678.
REQ-033 SHALL cover a write completing with PSLVERR=1 -> rsp_slverr=1 and rsp_timeout=0, with req_ready high in the rsp_valid cycle.
REQ-034 SHALL cover TIMEOUT_CYCLES=4 with the macro defined and PREADY held low -> abort after 4 ACCESS cycles, rsp_slverr=1, rsp_timeout=1; the same stimulus with the macro undefined -> still in ACCESS after 100 cycles.
REQ-035 SHALL cover PRESETn asserted in ACCESS -> PSEL and PENABLE at 0 without a clock edge, and no rsp_valid after release.
REQ-036 SHALL cover req_valid held high for 3 back-to-back commands -> each accepted only in IDLE, 3 rsp_valid pulses in order, and PSEL low for one cycle between transfers.
